udp_rx_seq_checker: RTL

- Sink-side checker for the user read stream of the UDP top level (rd_data/rd_valid/rd_last/rd_ready).
- Consumes frames produced by the incrementing-counter stimulus after the full UDP/RGMII loop.
- Verifies per-beat sequence continuity and per-frame beat count, and exposes counters and status for bench and on-chip debug.
- Synthesizable; runs in the user read clock domain.

---
 rtl/udp_seq_chk_pkg.sv | 28 ++
 rtl/udp_seq_chk_lfsr.sv | 41 ++++
 rtl/udp_rx_seq_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/udp_seq_chk_pkg.sv
// udp_seq_chk_pkg
//   Shared definitions for the UDP read-stream sequence checker:
//   - checker state encoding (SYNC / FRAME / GAP)
//   - ready-generator LFSR seed, tap mask and next-state helper
//   - bit positions of the error events that are OR-ed into err_pulse
package udp_seq_chk_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } chk_state_e;

    // Fibonacci LFSR, taps 16,14,13,11 -> bit indices 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Error-event vector layout.
    localparam int EV_SEQ    = 0;
    localparam int EV_LEN    = 1;
    localparam int EV_RESYNC = 2;
    localparam int EV_W      = 3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/udp_seq_chk_lfsr.sv
// udp_seq_chk_lfsr
//   Back-pressure generator for the sequence checker. A 16-bit Fibonacci
//   LFSR advances every cycle; ready is dropped whenever the two low bits
//   are both zero (roughly one cycle in four).
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous active-high reset (LFSR reloads its seed)
//     rd_ready  out  ready towards the stream source, 0 during reset
module udp_seq_chk_lfsr
    import udp_seq_chk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic rd_ready
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        run_q;
    logic        run_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        run_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            run_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            run_q  <= run_d;
        end
    end

    // run_q keeps ready low while in reset even though the seed's low bits
    // are non-zero.
    assign rd_ready = run_q && (lfsr_q[1:0] != 2'b00);

endmodule

// File: rtl/udp_rx_seq_checker.sv
// udp_rx_seq_checker
//   Sink-side checker for the user read stream of the UDP top level. It
//   expects an incrementing counter pattern, checks beat-to-beat continuity
//   (across frame boundaries too) and the number of beats per frame, and
//   exposes counters/status for the bench and on-chip debug.
//   Optional feature macro: UDP_SEQ_CHK_BACKPRESSURE_EN - when defined,
//   rd_ready is driven by a pseudo-random stall generator; otherwise it is
//   constant 1 after reset.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     rd_data/valid/last    input stream; rd_ready output
//     frame_cnt, beat_cnt   terminated frames / accepted beats (wrapping)
//     seq_err_cnt           continuity errors (saturating)
//     len_err_cnt           wrong-length or overrun frames (saturating)
//     resync_cnt            restarts on a data==0 beat (saturating)
//     err_pulse             one-cycle pulse on any error event
//     locked                a reference value is held
//     last_data             data of the most recent accepted beat
module udp_rx_seq_checker
    import udp_seq_chk_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int EXP_LEN   = 23,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 32,
    parameter int ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    input  logic              rd_last,
    output logic              rd_ready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [ERR_W-1:0]  seq_err_cnt,
    output logic [ERR_W-1:0]  len_err_cnt,
    output logic [ERR_W-1:0]  resync_cnt,
    output logic              err_pulse,
    output logic              locked,
    output logic [DATA_W-1:0] last_data
);

    // idx must be able to hold MAX_BEATS itself.
    localparam int IDX_W = $clog2(MAX_BEATS + 1);

    chk_state_e        state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ERR_W-1:0]  seq_err_cnt_q, seq_err_cnt_d;
    logic [ERR_W-1:0]  len_err_cnt_q, len_err_cnt_d;
    logic [ERR_W-1:0]  resync_cnt_q, resync_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              locked_q, locked_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;

    logic              ready;
    logic              accept;
    logic [IDX_W-1:0]  idx_inc;
    logic [EV_W-1:0]   ev;

`ifdef UDP_SEQ_CHK_BACKPRESSURE_EN
    udp_seq_chk_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .rd_ready (ready)
    );
`else
    logic ready_q;
    logic ready_d;

    always_comb begin
        ready_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
`endif

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        seq_err_cnt_d = seq_err_cnt_q;
        len_err_cnt_d = len_err_cnt_q;
        resync_cnt_d  = resync_cnt_q;
        locked_d      = locked_q;
        last_data_d   = last_data_q;
        ev            = '0;

        accept  = rd_valid && ready;
        // Beat number of the current beat within its frame (1-based). In
        // GAP idx is already cleared, so FRAME and GAP share one rule.
        idx_inc = (state_q == SYNC) ? IDX_W'(1) : idx_q + 1'b1;

        if (accept) begin
            beat_cnt_d  = beat_cnt_q + 1'b1;
            last_data_d = rd_data;
            exp_d       = rd_data + 1'b1;
            locked_d    = 1'b1;
            idx_d       = idx_inc;

            // No reference exists yet in SYNC, so the first beat is free.
            if (state_q != SYNC && rd_data != exp_q) begin
                if (rd_data == '0) begin
                    ev[EV_RESYNC] = 1'b1;
                end else begin
                    ev[EV_SEQ] = 1'b1;
                end
            end

            if (rd_last) begin
                if (idx_inc != IDX_W'(EXP_LEN)) begin
                    ev[EV_LEN] = 1'b1;
                end
                frame_cnt_d = frame_cnt_q + 1'b1;
                idx_d       = '0;
                state_d     = GAP;
            end else if (idx_inc == IDX_W'(MAX_BEATS)) begin
                // Unterminated frame: drop the reference and relock.
                ev[EV_LEN] = 1'b1;
                locked_d   = 1'b0;
                idx_d      = '0;
                state_d    = SYNC;
            end else begin
                state_d = FRAME;
            end
        end

        // Error counters stick at all-ones.
        if (ev[EV_SEQ] && seq_err_cnt_q != '1) begin
            seq_err_cnt_d = seq_err_cnt_q + 1'b1;
        end
        if (ev[EV_LEN] && len_err_cnt_q != '1) begin
            len_err_cnt_d = len_err_cnt_q + 1'b1;
        end
        if (ev[EV_RESYNC] && resync_cnt_q != '1) begin
            resync_cnt_d = resync_cnt_q + 1'b1;
        end

        err_pulse_d = |ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SYNC;
            exp_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            beat_cnt_q    <= '0;
            seq_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
            resync_cnt_q  <= '0;
            err_pulse_q   <= 1'b0;
            locked_q      <= 1'b0;
            last_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            seq_err_cnt_q <= seq_err_cnt_d;
            len_err_cnt_q <= len_err_cnt_d;
            resync_cnt_q  <= resync_cnt_d;
            err_pulse_q   <= err_pulse_d;
            locked_q      <= locked_d;
            last_data_q   <= last_data_d;
        end
    end

    assign rd_ready    = ready;
    assign frame_cnt   = frame_cnt_q;
    assign beat_cnt    = beat_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign len_err_cnt = len_err_cnt_q;
    assign resync_cnt  = resync_cnt_q;
    assign err_pulse   = err_pulse_q;
    assign locked      = locked_q;
    assign last_data   = last_data_q;

endmodule
